// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential RV32M divider.
// Holds the FSM state encoding, funct3 opcodes and operand width.
package div_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] M_DIV  = 3'b100;
  localparam logic [2:0] M_DIVU = 3'b101;
  localparam logic [2:0] M_REM  = 3'b110;
  localparam logic [2:0] M_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } div_state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == M_DIV) || (op == M_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == M_REM) || (op == M_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: combinational, zero latency.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module div_step #(
  parameter int W = div_seq_pkg::XLEN
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem < dvs always holds, so shifted < 2*dvs and bit W of diff is the borrow
  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential RV32M divider: 34 cycles accept-to-done (1 for div-by-zero/overflow).
// No queueing: start is ignored while busy; kill aborts and suppresses done.
module div_seq #(
  parameter int XLEN = div_seq_pkg::XLEN
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res,
  output logic [4:0]      rd_out
);

  import div_seq_pkg::*;

  div_state_t state;
  div_state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic             neg_q;
  logic             neg_r;
  logic             is_rem;
  logic [4:0]       tag;

  logic             accept;
  logic             signed_op;
  logic             b_zero;
  logic             overflow;
  logic             special;
  logic [XLEN-1:0]  spec_res;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic [XLEN-1:0]  fix_res;
  logic [XLEN-1:0]  step_rem;
  logic             step_q;

  // Accept decode and the single-cycle special cases
  always_comb begin
    signed_op = op_is_signed(m_op);
    accept    = (state == S_IDLE) && start && !kill && m_op[2];
    b_zero    = (op_b == '0);
    overflow  = signed_op && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special   = b_zero || overflow;
    if (b_zero)
      spec_res = op_is_rem(m_op) ? op_a : '1;
    else
      spec_res = op_is_rem(m_op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    a_mag = (signed_op && op_a[XLEN-1]) ? -op_a : op_a;
    b_mag = (signed_op && op_b[XLEN-1]) ? -op_b : op_b;
  end

  div_step #(
    .W (XLEN)
  ) u_step (
    .rem      (rem),
    .dvd_bit  (quo[XLEN-1]),
    .dvs      (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    if (is_rem)
      fix_res = neg_r ? -rem : rem;
    else
      fix_res = neg_q ? -quo : quo;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_next = special ? S_DONE : S_DIVIDE;
      end
      S_DIVIDE: begin
        if (cnt == '0)
          state_next = S_FIXUP;
      end
      S_FIXUP:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (kill)
      state_next = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE) && !kill;
  end

  // Operand, iteration and result registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      tag    <= '0;
      res    <= '0;
      rd_out <= '0;
    end else begin
      if (accept) begin
        quo    <= a_mag;
        dvs    <= b_mag;
        rem    <= '0;
        cnt    <= CNT_W'(XLEN - 1);
        neg_q  <= signed_op && (op_a[XLEN-1] ^ op_b[XLEN-1]);
        neg_r  <= signed_op && op_a[XLEN-1];
        is_rem <= op_is_rem(m_op);
        tag    <= rd;
      end else if (state == S_DIVIDE && !kill) begin
        rem <= step_rem;
        quo <= {quo[XLEN-2:0], step_q};
        if (cnt != '0)
          cnt <= cnt - 1'b1;
      end

      // Results only change on entry to DONE, so they hold between completions
      if (accept && special) begin
        res    <= spec_res;
        rd_out <= rd;
      end else if (state == S_FIXUP && !kill) begin
        res    <= fix_res;
        rd_out <= tag;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RV32M corner cases plus random ops
// against a plain-arithmetic reference model.
module tb_div_seq;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [2:0]  m_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .m_op   (m_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd     (rd),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_signed;
    bit want_rem;
    int sa;
    int sb;
    is_signed = (op == OP_DIV) || (op == OP_REM);
    want_rem  = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0)
      return want_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return want_rem ? 32'd0 : 32'h8000_0000;
    if (is_signed) begin
      sa = $signed(a);
      sb = $signed(b);
      return want_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return want_rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_signed;
    is_signed = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0 || (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return 1;
    return 34;
  endfunction

  // Called just after a negedge: start is presented for the very next edge.
  // With poke set, junk starts are driven mid-operation and in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit poke, input logic [31:0] exp);
    int  lat_exp;
    int  cyc;
    int  busy_cnt;
    bit  seen;
    lat_exp  = ref_lat(op, a, b);
    start    = 1'b1;
    m_op     = op;
    op_a     = a;
    op_b     = b;
    rd       = tag;
    cyc      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      start = poke && (cyc == 5 || seen);
      if (start) begin
        m_op = OP_DIV;
        op_a = $urandom;
        op_b = 32'd1;
        rd   = 5'd31;
      end
    end
    chk("latency", seen ? 32'(cyc) : 32'd0, 32'(lat_exp));
    chk("busy_cycles", 32'(busy_cnt), 32'(lat_exp));
    chk("res", res, exp);
    chk("rd_out", 32'(rd_out), 32'(tag));
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("res_hold", res, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          kd;
    int          bc;

    nrst  = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    m_op  = 3'b000;
    op_a  = 32'd0;
    op_b  = 32'd0;
    rd    = 5'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    run_op(OP_DIVU, 32'd100, 32'd7, 5'd1, 1'b0, 32'd14);
    run_op(OP_REMU, 32'd100, 32'd7, 5'd2, 1'b1, 32'd2);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0, 32'hFFFF_FFFD);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0, 32'hFFFF_FFFF);
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd5, 1'b0, 32'd1);
    run_op(OP_DIV,  32'd5, 32'd0, 5'd6, 1'b0, 32'hFFFF_FFFF);
    run_op(OP_REMU, 32'd5, 32'd0, 5'd7, 1'b1, 32'd5);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0, 32'h8000_0000);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'd0);

    // multiply-encoded start is ignored
    start = 1'b1;
    m_op  = 3'b001;
    op_a  = 32'd3;
    op_b  = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("mul_ignored", 32'(busy), 32'd0);
    @(negedge clk);

    // kill on cycle 10, then restart on the very next edge
    start = 1'b1;
    m_op  = OP_DIVU;
    op_a  = 32'd1000;
    op_b  = 32'd3;
    rd    = 5'd10;
    kd    = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) kd++;
      if (c == 10) kill = 1'b1;
    end
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_no_early_done", 32'(kd), 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd11, 1'b0, 32'd14);

    // asynchronous reset in the middle of DIVIDE
    start = 1'b1;
    m_op  = OP_DIVU;
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'd3;
    rd    = 5'd12;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    nrst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_res", res, 32'd0);
    chk("midrst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    kd = 0;
    bc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) kd++;
      if (busy) bc++;
    end
    chk("no_done_after_rst", 32'(kd), 32'd0);
    chk("no_busy_after_rst", 32'(bc), 32'd0);

    for (int i = 0; i < 40; i++) begin
      r_op = {1'b1, 2'($urandom_range(0, 3))};
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       r_b = 32'd0;
        1:       r_b = 32'hFFFF_FFFF;
        2:       r_b = 32'($urandom_range(1, 15));
        default: r_b = 32'($urandom);
      endcase
      run_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             ref_res(r_op, r_a, r_b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; only 32 is supported for RV32M.
REQ-002 clk  input  1  single clock for the block.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request from the issue stage to begin a divide or remainder.
REQ-005 m_op  input  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  XLEN  dividend (rs1).
REQ-007 op_b  input  XLEN  divisor (rs2).
REQ-008 rd  input  5  destination tag captured on accept.
REQ-009 kill  input  1  pipeline flush; aborts the operation in flight.
REQ-010 busy  output  1  high while the unit is occupied; drives the front-end stall.
REQ-011 done  output  1  one-cycle pulse; res and rd_out are valid.
REQ-012 res  output  XLEN  quotient or remainder.
REQ-013 rd_out  output  5  tag of the completed operation.

Function
REQ-014 The state machine SHALL have states IDLE, DIVIDE, FIXUP and DONE; busy = (state != IDLE), decoded from the state register.
REQ-015 An accept SHALL occur only on a clock edge with state IDLE, start=1, kill=0 and m_op[2]=1; at accept, op_a, op_b, m_op and rd are latched.
REQ-016 start with m_op[2]=0 (multiply ops) SHALL be ignored.
REQ-017 start while busy=1, including in the DONE cycle, SHALL be ignored; nothing is queued.
REQ-018 Special case, accept with op_b=0: IDLE->DONE; res = 0xFFFFFFFF for DIV/DIVU, res = op_a for REM/REMU.
REQ-019 Special case, accept with DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF: IDLE->DONE; res = 0x80000000 for DIV, res = 0 for REM.
REQ-020 Normal case: IDLE->DIVIDE.
- Signed ops divide the magnitudes.
- DIVIDE performs one restoring shift-subtract step per cycle for exactly XLEN cycles, using a 6-bit down-counter loaded with XLEN-1.
- The state moves to FIXUP when the counter is 0.
REQ-021 FIXUP SHALL apply signs in one cycle, then go to DONE.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-022 DONE SHALL assert done=1 for exactly that cycle, then go unconditionally to IDLE.
REQ-023 Latency, in cycles from the accept edge until done is high: normal = XLEN+2 (34); special case = 1.
REQ-024 res and rd_out SHALL be registered and SHALL hold their value after done until the next DONE.
REQ-025 kill=1 SHALL force the next state to IDLE from any state and suppress done; a simultaneous start SHALL not be accepted.
REQ-026 After kill or DONE, a new start SHALL be acceptable on the very next edge.

Reset
REQ-027 On nrst=0, the block SHALL immediately and asynchronously set: state IDLE, counter 0, all operand/partial registers 0, busy 0, done 0, res 0, rd_out 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no done is produced after release.

Structure
REQ-029 A shared package SHALL hold:
- the state enum (div_state_t);
- localparams for the m_op encodings (M_DIV, M_DIVU, M_REM, M_REMU);
- XLEN.
REQ-030 A single combinational sub-module div_step SHALL implement one restoring iteration (partial remainder, quotient bit); all other logic stays in div_seq.
REQ-031 The existing combinational mul_div path is unchanged; div_seq results are muxed into writeback on done.

Verification
REQ-032 DIVU 100/7 -> busy for 34 cycles, done on cycle 34, res=14; REMU same operands -> res=2.
REQ-033 DIV -7/2 -> res=0xFFFFFFFD; REM -7/2 -> res=0xFFFFFFFF; REM 7/-2 -> res=1.
REQ-034 DIV 5/0 -> res=0xFFFFFFFF; REMU 5/0 -> res=5; both with done one cycle after accept.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> res=0x80000000; REM with the same operands -> res=0.
REQ-036 DIVU started, kill on cycle 10 -> busy low the next cycle, no done ever; a start on the following edge completes normally with the correct rd_out.
REQ-037 nrst pulsed low during DIVIDE -> busy, done and res read 0 immediately; no done after release; start while busy and MUL-encoded start are both ignored.
